dig_ctrl_spi_frontend: RTL

SPI target front-end that turns raw pad-level SPI pins into single-cycle register-access strobes in the `clk_i` domain. It sits between the bidirectional PMOD pins (CS, MOSI, MISO, SCLK) and the controller's register file. It oversamples SPI mode 0 with synchronizers and edge detection, decodes a command byte, and runs auto-incrementing read or write bursts.

---
 rtl/dig_ctrl_spi_frontend.sv | 113 +++++++++++
 1 files changed

// File: rtl/dig_ctrl_spi_frontend.sv
// dig_ctrl_spi_frontend: oversampled SPI mode-0 target turning command/data frames into register strobes
module dig_ctrl_spi_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_i,
  output logic       spi_miso_o,
  output logic [6:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o,
  output logic       abort_o
);
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic sclk_q, armed, pf, re_q;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] tx, rx_byte;
  logic sclk_s, mosi_s, cs_s, rise, fall, byte_done, we_d, re_d, abort_d;

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign rise       = sclk_s & ~sclk_q;
  assign fall       = ~sclk_s & sclk_q;
  assign rx_byte    = {rx, mosi_s};
  assign byte_done  = rise && cnt == 3'd7 && state != IDLE;
  assign spi_miso_o = tx[7];
  assign busy_o     = armed & ~cs_s;

  // Synchronize the pins; armed stays low until CS is seen high, so a frame cut by reset is ignored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_q    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      sclk_q    <= sclk_s;
      armed     <= armed | cs_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_d;
  end

  // Next state and strobes; a completing byte defers a simultaneous CS rise by one cycle so its strobe lands outside IDLE
  always_comb begin
    state_d = state;
    we_d    = 1'b0;
    re_d    = 1'b0;
    abort_d = 1'b0;
    if (state == IDLE) begin
      state_d = (!cs_s && armed) ? CMD : IDLE;
    end else if (cs_s && !byte_done) begin
      state_d = IDLE;
      abort_d = cnt != 3'd0;
    end else begin
      we_d = state == WDATA && byte_done;
      re_d = (state == CMD && byte_done && !rx_byte[7]) || (state == RDATA && pf && !cs_s);
      if (state == CMD && byte_done) state_d = rx_byte[7] ? WDATA : RDATA;
    end
  end

  // Output strobes, address, bit counter and shift registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      abort_o     <= 1'b0;
      reg_wdata_o <= '0;
      reg_addr_o  <= '0;
      re_q        <= 1'b0;
      pf          <= 1'b0;
      cnt         <= '0;
      rx          <= '0;
      tx          <= '0;
    end else begin
      reg_we_o <= we_d;
      reg_re_o <= re_d;
      abort_o  <= abort_d;
      re_q     <= reg_re_o;
      pf       <= state == RDATA && byte_done;
      if (we_d) reg_wdata_o <= rx_byte;
      if (state == CMD && byte_done) reg_addr_o <= rx_byte[6:0];
      else if (reg_we_o || (state == RDATA && byte_done)) reg_addr_o <= reg_addr_o + 7'd1;
      if (state == IDLE) begin
        cnt <= '0;
        rx  <= '0;
      end else if (rise) begin
        cnt <= cnt + 3'd1;
        rx  <= rx_byte[6:0];
      end
      if (state == IDLE || state_d == IDLE) tx <= '0;
      else if (re_q) tx <= reg_rdata_i;
      else if (fall && cnt != 3'd0) tx <= {tx[6:0], 1'b0};
    end
  end
endmodule
